// File: rtl/score_sequencer.sv
// Game-flow sequencer for the snake game: start/food edge detection, score shadow and end-of-game hold.
// Optional macro SCORE_SEQ_AUTORESTART_EN: hold expiry restarts straight into PLAY instead of IDLE.
module score_sequencer #(
    parameter int MAX_SCORE  = 140,
    parameter int HOLD_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic       good_coll,
    input  logic       bad_coll,
    output logic       inc,
    output logic       clr,
    output logic       show_high,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic       game_complete
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2,
        WIN  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_S  = 8'(MAX_SCORE);
    localparam logic [7:0] HOLD_T = 8'(HOLD_TICKS);

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic [7:0] score_nxt;
    logic       start_prev;
    logic       good_prev;
    logic       inc_nxt;
    logic       clr_nxt;
    logic       start_edge;
    logic       food_edge;
    logic       hold_done;

    assign start_edge = start & ~start_prev;
    assign food_edge  = good_coll & ~good_prev;
    assign hold_done  = ({1'b0, hold_cnt} + 9'd1) >= {1'b0, HOLD_T};
    assign state      = cur_state;

    always_comb begin
        nxt_state = cur_state;
        score_nxt = score;
        hold_nxt  = hold_cnt;
        inc_nxt   = 1'b0;
        clr_nxt   = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start_edge) begin
                    nxt_state = PLAY;
                    clr_nxt   = 1'b1;
                    score_nxt = 8'd0;
                end
            end
            PLAY: begin
                // A collision always ends the game, even if food was reached in the same step.
                if (bad_coll) begin
                    nxt_state = OVER;
                    hold_nxt  = 8'd0;
                end else if (food_edge && (score < MAX_S)) begin
                    inc_nxt   = 1'b1;
                    score_nxt = score + 8'd1;
                    if ((score + 8'd1) == MAX_S) begin
                        nxt_state = WIN;
                        hold_nxt  = 8'd0;
                    end
                end
            end
            OVER, WIN: begin
                if (tick) begin
                    if (hold_done) begin
                        hold_nxt = 8'd0;
`ifdef SCORE_SEQ_AUTORESTART_EN
                        nxt_state = PLAY;
                        clr_nxt   = 1'b1;
                        score_nxt = 8'd0;
`else
                        nxt_state = IDLE;
`endif
                    end else begin
                        hold_nxt = hold_cnt + 8'd1;
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decision so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state     <= IDLE;
            score         <= 8'd0;
            hold_cnt      <= 8'd0;
            start_prev    <= 1'b0;
            good_prev     <= 1'b0;
            inc           <= 1'b0;
            clr           <= 1'b0;
            show_high     <= 1'b0;
            game_complete <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            score         <= score_nxt;
            hold_cnt      <= hold_nxt;
            start_prev    <= start;
            good_prev     <= good_coll;
            inc           <= inc_nxt;
            clr           <= clr_nxt;
            show_high     <= (nxt_state == OVER) || (nxt_state == WIN);
            game_complete <= (nxt_state == OVER) || (nxt_state == WIN);
        end
    end

endmodule
